// File: rtl/select_clock_param_if.sv
// Control/status bundle of the timer prescaler.
//   en          : prescaler run enable            (master -> slave)
//   clr         : synchronous prescaler clear     (master -> slave)
//   cks         : requested divider select        (master -> slave)
//   int_clk     : one-cycle count-enable pulse    (slave -> master)
//   int_clk_lvl : ~50% square wave at clk/D       (slave -> master)
//   sel_pend    : requested select not yet active (slave -> master)
//   presc_cnt   : current prescale count          (slave -> master)
interface select_clock_param_if #(
  parameter int unsigned CKS_W = 2,
  parameter int unsigned BASE  = 1
);
  localparam int unsigned CNT_W = BASE + (32'd1 << CKS_W) - 1;

  logic             en;
  logic             clr;
  logic [CKS_W-1:0] cks;
  logic             int_clk;
  logic             int_clk_lvl;
  logic             sel_pend;
  logic [CNT_W-1:0] presc_cnt;

  modport master (
    output en, clr, cks,
    input  int_clk, int_clk_lvl, sel_pend, presc_cnt
  );

  modport slave (
    input  en, clr, cks,
    output int_clk, int_clk_lvl, sel_pend, presc_cnt
  );
endinterface

// File: rtl/select_clock_param.sv
// Parametrised prescaler and glitch-free clock-enable selector.
// Produces a one-cycle int_clk pulse every 2^(BASE+sel) clocks; a new divider
// select is adopted only on a period boundary or while the prescaler is idle.
//   clk      : system clock, rising edge
//   preset_n : asynchronous active-low reset
//   bus      : slave side of select_clock_param_if (en/clr/cks in, status out)
module select_clock_param #(
  parameter int unsigned CKS_W = 2,
  parameter int unsigned BASE  = 1
) (
  input  logic                 clk,
  input  logic                 preset_n,
  select_clock_param_if.slave  bus
);
  localparam int unsigned CNT_W = BASE + (32'd1 << CKS_W) - 1;

  // Low-order ones covering one period of the given select.
  function automatic logic [CNT_W-1:0] mask_of(input logic [CKS_W-1:0] s);
    logic [31:0] m;
    m = (32'd1 << (BASE + 32'(s))) - 32'd1;
    return m[CNT_W-1:0];
  endfunction

  // Top bit of the period mask: high during the second half of a period.
  function automatic logic [CNT_W-1:0] half_of(input logic [CKS_W-1:0] s);
    logic [CNT_W-1:0] m;
    m = mask_of(s);
    return m ^ (m >> 1);
  endfunction

  logic [CNT_W-1:0] r_cnt;
  logic [CKS_W-1:0] r_req_sel;
  logic [CKS_W-1:0] r_act_sel;
  logic             r_int_clk;
  logic             r_int_clk_lvl;
  logic             r_sel_pend;

  logic [CNT_W-1:0] w_mask;
  logic             w_tick;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CKS_W-1:0] w_act_nxt;
  logic             w_int_nxt;
  logic             w_lvl_nxt;
  logic             w_pend_nxt;

  assign w_mask = mask_of(r_act_sel);
  assign w_tick = bus.en & ((r_cnt & w_mask) == w_mask);

  // Next-state: clear > stopped > boundary > plain count.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_act_nxt = r_act_sel;
    w_int_nxt = 1'b0;
    w_lvl_nxt = r_int_clk_lvl;
    if (bus.clr) begin
      w_cnt_nxt = '0;
      w_lvl_nxt = 1'b0;
      w_act_nxt = r_req_sel;
    end else if (!bus.en) begin
      // Idle prescaler: no period in flight, so switching cannot glitch.
      w_act_nxt = r_req_sel;
    end else begin
      if (w_tick) begin
        w_int_nxt = 1'b1;
        if (r_req_sel != r_act_sel) begin
          // Restart from zero so the first new period is a full one.
          w_act_nxt = r_req_sel;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
      w_lvl_nxt = |(w_cnt_nxt & half_of(w_act_nxt));
    end
    // cks is what req_sel becomes on this edge.
    w_pend_nxt = (bus.cks != w_act_nxt);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge preset_n) begin
    if (!preset_n) begin
      r_cnt         <= '0;
      r_req_sel     <= '0;
      r_act_sel     <= '0;
      r_int_clk     <= 1'b0;
      r_int_clk_lvl <= 1'b0;
      r_sel_pend    <= 1'b0;
    end else begin
      r_cnt         <= w_cnt_nxt;
      r_req_sel     <= bus.cks;
      r_act_sel     <= w_act_nxt;
      r_int_clk     <= w_int_nxt;
      r_int_clk_lvl <= w_lvl_nxt;
      r_sel_pend    <= w_pend_nxt;
    end
  end

  assign bus.int_clk     = r_int_clk;
  assign bus.int_clk_lvl = r_int_clk_lvl;
  assign bus.sel_pend    = r_sel_pend;
  assign bus.presc_cnt   = r_cnt;
endmodule
